// File: rtl/gate_rr_arbiter.sv
// gate_rr_arbiter: round-robin sequencer that shares one registered 2-input OR
// unit between N_REQ requesters. One requester is granted at a time. Its operands
// are captured and OR-ed together. The result is returned with the winner's ID
// over a valid/ready response port.
//
// Optional build macro: GATE_RR_ARB_CNT_EN adds done_cnt, a 16-bit wrapping count
// of completed response handshakes.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   req        level request per requester
//   op_a/op_b  packed operands, requester i at [i*WIDTH +: WIDTH]
//   gnt        one-hot single-cycle grant pulse (operands captured that cycle)
//   rsp_valid  result available
//   rsp_ready  consumer accepts result
//   rsp_data   op_a | op_b of the granted requester
//   rsp_id     index of the granted requester
//   done_cnt   completed handshakes (GATE_RR_ARB_CNT_EN only)
//   busy       high whenever the sequencer is not idle
module gate_rr_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = 2,
    parameter int unsigned WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] op_a,
    input  logic [N_REQ*WIDTH-1:0] op_b,
    output logic [N_REQ-1:0]       gnt,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [WIDTH-1:0]       rsp_data,
    output logic [ID_W-1:0]        rsp_id,
`ifdef GATE_RR_ARB_CNT_EN
    output logic [15:0]            done_cnt,
`endif
    output logic                   busy
);

    typedef enum logic [1:0] {StIdle, StGrant, StExec, StResp} state_t;

    state_t           state;
    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  win_id;
    logic [WIDTH-1:0] cap_a;
    logic [WIDTH-1:0] cap_b;

    logic [ID_W-1:0]  pick;
    logic [ID_W:0]    idx;
    logic             win_req;
    logic [WIDTH-1:0] win_a;
    logic [WIDTH-1:0] win_b;
    logic [ID_W-1:0]  next_ptr;

    // Scan from the highest offset down so the lowest offset above ptr wins.
    always_comb begin
        pick = ptr;
        idx  = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = {1'b0, ptr} + (ID_W + 1)'(i);
            if (idx >= (ID_W + 1)'(N_REQ)) begin
                idx = idx - (ID_W + 1)'(N_REQ);
            end
            if (req[idx[ID_W-1:0]]) begin
                pick = idx[ID_W-1:0];
            end
        end
    end

    assign win_req  = req[win_id];
    assign win_a    = op_a[int'(win_id) * WIDTH +: WIDTH];
    assign win_b    = op_b[int'(win_id) * WIDTH +: WIDTH];
    assign next_ptr = (win_id == ID_W'(N_REQ - 1)) ? '0 : win_id + 1'b1;
    assign busy     = (state != StIdle);

    // The grant must follow req in the same cycle so that a withdrawal during
    // GRANT suppresses it; hence it is decoded rather than registered.
    always_comb begin
        gnt = '0;
        if (state == StGrant && win_req) begin
            gnt[win_id] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            ptr       <= '0;
            win_id    <= '0;
            cap_a     <= '0;
            cap_b     <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
`ifdef GATE_RR_ARB_CNT_EN
            done_cnt  <= '0;
`endif
        end else begin
            case (state)
                StIdle: begin
                    if (|req) begin
                        win_id <= pick;
                        state  <= StGrant;
                    end
                end
                StGrant: begin
                    if (win_req) begin
                        cap_a <= win_a;
                        cap_b <= win_b;
                        state <= StExec;
                    end else begin
                        state <= StIdle;
                    end
                end
                StExec: begin
                    rsp_data  <= cap_a | cap_b;
                    rsp_id    <= win_id;
                    rsp_valid <= 1'b1;
                    state     <= StResp;
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        ptr       <= next_ptr;
                        state     <= StIdle;
`ifdef GATE_RR_ARB_CNT_EN
                        done_cnt  <= done_cnt + 16'd1;
`endif
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
